// File: rtl/pkgs.sv
// Shared types and constants for the data-memory arbiter.
package pkgs;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 19;

    // Access-size encoding used on every byte_en bus.
    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Bit 0 is the core port, bit 1 the debug port.
module rr_arb2
    import pkgs::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    // A lone requester wins; on a tie the port that did not win last time goes.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_owner == DBG) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer for the single-port data memory shared by the core
// data port and the debug/DMA port. One registered transaction at a time;
// read returns are timed by a fixed-latency counter.
//
// Handshake: a requester raises req with a stable payload and holds both
// until gnt pulses for one cycle (the request is accepted in that cycle).
// Completion is a one-cycle rvalid pulse on the owning port; reads carry
// rdata with it, writes return rdata = 0. rdata is 0 whenever rvalid is low.
module dmem_arbiter
    import pkgs::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        core_req_i,
    input  logic [18:0] core_addr_i,
    input  logic [1:0]  core_byte_en_i,
    input  logic        core_wr_i,
    input  logic [18:0] core_wr_data_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [18:0] core_rdata_o,

    input  logic        dbg_req_i,
    input  logic [18:0] dbg_addr_i,
    input  logic [1:0]  dbg_byte_en_i,
    input  logic        dbg_wr_i,
    input  logic [18:0] dbg_wr_data_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [18:0] dbg_rdata_o,

    output logic        mem_req_o,
    output logic [18:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [18:0] mem_wr_data_o,
    input  logic [18:0] mem_rd_data_i,

    output logic        busy_o
);

    // The counter reaches 0 in the cycle the memory presents read data.
    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    arb_state_t  state_q;
    arb_state_t  state_d;
    port_t       owner_q;
    port_t       last_owner_q;
    logic [2:0]  cnt_q;
    logic [18:0] addr_q;
    logic [18:0] wdata_q;
    logic [18:0] rdata_q;
    logic [1:0]  be_q;
    logic        wr_q;
    logic [1:0]  req;
    logic [1:0]  arb_gnt;
    logic [1:0]  gnt;

    assign req = {dbg_req_i, core_req_i};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_owner (last_owner_q),
        .gnt        (arb_gnt)
    );

    // Grants are only offered in IDLE, and never while reset is asserted so
    // that every output reads 0 during reset.
    assign gnt        = (state_q == IDLE && reset_n) ? arb_gnt : 2'b00;
    assign core_gnt_o = gnt[0];
    assign dbg_gnt_o  = gnt[1];
    assign busy_o     = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant -> issue -> (wait for reads) -> respond.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt != 2'b00) state_d = ISSUE;
            ISSUE:   state_d = wr_q ? RESP : WAIT;
            WAIT:    if (cnt_q == 3'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload/owner latch on grant, latency counter and read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q      <= CORE;
            last_owner_q <= DBG;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            be_q         <= '0;
            wr_q         <= 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                owner_q      <= port_t'(gnt[1]);
                last_owner_q <= port_t'(gnt[1]);
                if (gnt[1]) begin
                    addr_q  <= dbg_addr_i;
                    be_q    <= dbg_byte_en_i;
                    wr_q    <= dbg_wr_i;
                    wdata_q <= dbg_wr_data_i;
                end else begin
                    addr_q  <= core_addr_i;
                    be_q    <= core_byte_en_i;
                    wr_q    <= core_wr_i;
                    wdata_q <= core_wr_data_i;
                end
            end
            if (state_q == ISSUE && !wr_q) begin
                cnt_q <= CNT_LOAD;
            end
            if (state_q == WAIT) begin
                if (cnt_q == 3'd0) begin
                    rdata_q <= mem_rd_data_i;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
            end
        end
    end

    // Outputs: memory strobe only in ISSUE, completion only to the owner in RESP.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        mem_byte_en_o = '0;
        mem_wr_o      = 1'b0;
        mem_wr_data_o = '0;
        core_rvalid_o = 1'b0;
        core_rdata_o  = '0;
        dbg_rvalid_o  = 1'b0;
        dbg_rdata_o   = '0;
        case (state_q)
            ISSUE: begin
                mem_req_o     = 1'b1;
                mem_addr_o    = addr_q;
                mem_byte_en_o = be_q;
                mem_wr_o      = wr_q;
                mem_wr_data_o = wdata_q;
            end
            RESP: begin
                if (owner_q == DBG) begin
                    dbg_rvalid_o = 1'b1;
                    dbg_rdata_o  = wr_q ? 19'd0 : rdata_q;
                end else begin
                    core_rvalid_o = 1'b1;
                    core_rdata_o  = wr_q ? 19'd0 : rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: main instance with RD_LAT=3, plus RD_LAT=1 and 7
// instances driven with back-to-back reads.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import pkgs::*;

    localparam int LAT = 3;
    localparam logic [18:0] SWEEP_ADDR = 19'h00040;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset_n;
    logic sweep_rst_n;

    // ---------------- main DUT signals ----------------
    logic        core_req_i, core_wr_i, dbg_req_i, dbg_wr_i;
    logic [18:0] core_addr_i, core_wr_data_i, dbg_addr_i, dbg_wr_data_i;
    logic [1:0]  core_byte_en_i, dbg_byte_en_i;
    logic        core_gnt_o, core_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
    logic [18:0] core_rdata_o, dbg_rdata_o;
    logic        mem_req_o, mem_wr_o, busy_o;
    logic [18:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
    logic [1:0]  mem_byte_en_o;

    dmem_arbiter #(.RD_LAT(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_byte_en_i(core_byte_en_i),
        .core_wr_i(core_wr_i), .core_wr_data_i(core_wr_data_i), .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_byte_en_i(dbg_byte_en_i),
        .dbg_wr_i(dbg_wr_i), .dbg_wr_data_i(dbg_wr_data_i), .dbg_gnt_o(dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
        .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i),
        .busy_o(busy_o)
    );

    // ---------------- sweep DUTs (core reads only) ----------------
    logic        s1_req, s7_req;
    logic        s_wr = 1'b0, z1 = 1'b0;
    logic [18:0] s_addr = SWEEP_ADDR, z19 = 19'd0;
    logic [1:0]  s_be = WORD, z2 = 2'd0;
    logic        s1_gnt, s1_rv, s1_dgnt, s1_drv, s1_mreq, s1_mwr, s1_busy;
    logic        s7_gnt, s7_rv, s7_dgnt, s7_drv, s7_mreq, s7_mwr, s7_busy;
    logic [18:0] s1_rd, s1_drd, s1_maddr, s1_mwd, s1_mrd;
    logic [18:0] s7_rd, s7_drd, s7_maddr, s7_mwd, s7_mrd;
    logic [1:0]  s1_mbe, s7_mbe;

    dmem_arbiter #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .reset_n(sweep_rst_n),
        .core_req_i(s1_req), .core_addr_i(s_addr), .core_byte_en_i(s_be),
        .core_wr_i(s_wr), .core_wr_data_i(z19), .core_gnt_o(s1_gnt),
        .core_rvalid_o(s1_rv), .core_rdata_o(s1_rd),
        .dbg_req_i(z1), .dbg_addr_i(z19), .dbg_byte_en_i(z2),
        .dbg_wr_i(z1), .dbg_wr_data_i(z19), .dbg_gnt_o(s1_dgnt),
        .dbg_rvalid_o(s1_drv), .dbg_rdata_o(s1_drd),
        .mem_req_o(s1_mreq), .mem_addr_o(s1_maddr), .mem_byte_en_o(s1_mbe),
        .mem_wr_o(s1_mwr), .mem_wr_data_o(s1_mwd), .mem_rd_data_i(s1_mrd),
        .busy_o(s1_busy)
    );

    dmem_arbiter #(.RD_LAT(7)) u_lat7 (
        .clk(clk), .reset_n(sweep_rst_n),
        .core_req_i(s7_req), .core_addr_i(s_addr), .core_byte_en_i(s_be),
        .core_wr_i(s_wr), .core_wr_data_i(z19), .core_gnt_o(s7_gnt),
        .core_rvalid_o(s7_rv), .core_rdata_o(s7_rd),
        .dbg_req_i(z1), .dbg_addr_i(z19), .dbg_byte_en_i(z2),
        .dbg_wr_i(z1), .dbg_wr_data_i(z19), .dbg_gnt_o(s7_dgnt),
        .dbg_rvalid_o(s7_drv), .dbg_rdata_o(s7_drd),
        .mem_req_o(s7_mreq), .mem_addr_o(s7_maddr), .mem_byte_en_o(s7_mbe),
        .mem_wr_o(s7_mwr), .mem_wr_data_o(s7_mwd), .mem_rd_data_i(s7_mrd),
        .busy_o(s7_busy)
    );

    // ---------------- memory model ----------------
    function automatic logic [18:0] mem_fn(input logic [18:0] a);
        if (a == 19'h00020) return 19'h12345;
        return a ^ 19'h2B5A3;
    endfunction

    logic        pipe_v [3][8];
    logic [18:0] pipe_d [3][8];
    logic [2:0]  m_req, m_wr;
    logic [18:0] m_addr [3];
    assign m_req = {s7_mreq, s1_mreq, mem_req_o};
    assign m_wr  = {s7_mwr, s1_mwr, mem_wr_o};
    assign m_addr[0] = mem_addr_o;
    assign m_addr[1] = s1_maddr;
    assign m_addr[2] = s7_maddr;

    initial begin
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 8; k++) begin
                pipe_v[i][k] = 1'b0;
                pipe_d[i][k] = 19'd0;
            end
    end

    // Stage k holds data valid k cycles after the memory strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 7; k >= 2; k--) begin
                pipe_v[i][k] <= pipe_v[i][k-1];
                pipe_d[i][k] <= pipe_d[i][k-1];
            end
            pipe_v[i][1] <= m_req[i] & ~m_wr[i];
            pipe_d[i][1] <= mem_fn(m_addr[i]);
        end
    end

    // Garbage outside the valid cycle so a mistimed capture shows up.
    assign mem_rd_data_i = pipe_v[0][LAT] ? pipe_d[0][LAT] : 19'h7FFFF;
    assign s1_mrd        = pipe_v[1][1]   ? pipe_d[1][1]   : 19'h7FFFF;
    assign s7_mrd        = pipe_v[2][7]   ? pipe_d[2][7]   : 19'h7FFFF;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic        wr;
        logic [18:0] addr;
        logic [1:0]  be;
        logic [18:0] wdata;
    } mem_exp_t;

    logic [18:0] core_exp_q[$];
    logic [18:0] dbg_exp_q[$];
    mem_exp_t    mem_exp_q[$];
    logic        gnt_log_q[$];
    int          out_gnt_cyc [2];
    logic        out_wr [2];
    int          last_rv_cyc [2];
    int          rv_count [2];
    mem_exp_t    me;
    logic        prev_core_req = 1'b0, prev_dbg_req = 1'b0;
    logic        prev_core_gnt = 1'b0, prev_dbg_gnt = 1'b0;
    logic [40:0] prev_core_pay, prev_dbg_pay;

    task automatic check_resp(input int p, input logic rv, input logic [18:0] rd);
        logic [18:0] e;
        int qs;
        qs = (p == 0) ? core_exp_q.size() : dbg_exp_q.size();
        if (rv) begin
            last_rv_cyc[p] = cyc;
            rv_count[p]++;
            if (qs == 0) begin
                check_eq(p == 0 ? "core_rvalid_unexp" : "dbg_rvalid_unexp", 64'(rv), 64'(0));
            end else begin
                if (p == 0) e = core_exp_q.pop_front();
                else        e = dbg_exp_q.pop_front();
                check_eq(p == 0 ? "core_rdata" : "dbg_rdata", 64'(rd), 64'(e));
                check_eq(p == 0 ? "core_latency" : "dbg_latency",
                         64'(cyc - out_gnt_cyc[p]), 64'(out_wr[p] ? 2 : 2 + LAT));
            end
        end else begin
            check_eq(p == 0 ? "core_rdata_idle" : "dbg_rdata_idle", 64'(rd), 64'(0));
        end
    endtask

    // Monitor for the main instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (core_gnt_o || dbg_gnt_o) begin
                check_eq("gnt_onehot", 64'(core_gnt_o & dbg_gnt_o), 64'(0));
                if (dbg_gnt_o) begin
                    gnt_log_q.push_back(1'b1);
                    mem_exp_q.push_back({32'(cyc + 1), dbg_wr_i, dbg_addr_i, dbg_byte_en_i, dbg_wr_data_i});
                    out_gnt_cyc[1] = cyc;
                    out_wr[1] = dbg_wr_i;
                end else begin
                    gnt_log_q.push_back(1'b0);
                    mem_exp_q.push_back({32'(cyc + 1), core_wr_i, core_addr_i, core_byte_en_i, core_wr_data_i});
                    out_gnt_cyc[0] = cyc;
                    out_wr[0] = core_wr_i;
                end
            end
            if (mem_req_o) begin
                if (mem_exp_q.size() == 0) begin
                    check_eq("mem_req_unexp", 64'(mem_req_o), 64'(0));
                end else begin
                    me = mem_exp_q.pop_front();
                    check_eq("mem_req_cycle", 64'(cyc), 64'(me.cyc));
                    check_eq("mem_addr", 64'(mem_addr_o), 64'(me.addr));
                    check_eq("mem_byte_en", 64'(mem_byte_en_o), 64'(me.be));
                    check_eq("mem_wr", 64'(mem_wr_o), 64'(me.wr));
                    check_eq("mem_wr_data", 64'(mem_wr_data_o), 64'(me.wdata));
                end
            end else begin
                check_eq("mem_idle", 64'({mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o}), 64'(0));
            end
            if (core_rvalid_o && dbg_rvalid_o)
                check_eq("rvalid_onehot", 64'(core_rvalid_o & dbg_rvalid_o), 64'(0));
            check_resp(0, core_rvalid_o, core_rdata_o);
            check_resp(1, dbg_rvalid_o, dbg_rdata_o);
            if (prev_core_req && !prev_core_gnt)
                check_eq("core_req_hold",
                         64'({core_req_i, core_wr_i, core_addr_i, core_byte_en_i, core_wr_data_i}),
                         64'({1'b1, prev_core_pay}));
            if (prev_dbg_req && !prev_dbg_gnt)
                check_eq("dbg_req_hold",
                         64'({dbg_req_i, dbg_wr_i, dbg_addr_i, dbg_byte_en_i, dbg_wr_data_i}),
                         64'({1'b1, prev_dbg_pay}));
        end
        prev_core_req = core_req_i & reset_n;
        prev_dbg_req  = dbg_req_i & reset_n;
        prev_core_gnt = core_gnt_o;
        prev_dbg_gnt  = dbg_gnt_o;
        prev_core_pay = {core_wr_i, core_addr_i, core_byte_en_i, core_wr_data_i};
        prev_dbg_pay  = {dbg_wr_i, dbg_addr_i, dbg_byte_en_i, dbg_wr_data_i};
    end

    // Sweep monitor: rvalid spacing and data on the two latency corners.
    int s1_last = -1, s7_last = -1, s1_n = 0, s7_n = 0;
    always @(negedge clk) begin
        if (sweep_rst_n) begin
            if (s1_rv) begin
                check_eq("lat1_rdata", 64'(s1_rd), 64'(mem_fn(SWEEP_ADDR)));
                if (s1_last >= 0) check_eq("lat1_spacing", 64'(cyc - s1_last), 64'(4));
                s1_last = cyc;
                s1_n++;
            end
            if (s7_rv) begin
                check_eq("lat7_rdata", 64'(s7_rd), 64'(mem_fn(SWEEP_ADDR)));
                if (s7_last >= 0) check_eq("lat7_spacing", 64'(cyc - s7_last), 64'(10));
                s7_last = cyc;
                s7_n++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic wr, input logic [18:0] addr,
                           input logic [1:0] be, input logic [18:0] wdata);
        logic [18:0] e;
        e = wr ? 19'd0 : mem_fn(addr);
        if (p == 0) begin
            core_exp_q.push_back(e);
            core_wr_i = wr; core_addr_i = addr; core_byte_en_i = be; core_wr_data_i = wdata;
            core_req_i = 1'b1;
        end else begin
            dbg_exp_q.push_back(e);
            dbg_wr_i = wr; dbg_addr_i = addr; dbg_byte_en_i = be; dbg_wr_data_i = wdata;
            dbg_req_i = 1'b1;
        end
    endtask

    // Waits (bounded) for the port's grant, then drops the request after the edge.
    task automatic wait_gnt(input int p, output int n);
        n = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((p == 0) ? core_gnt_o : dbg_gnt_o) begin
                n = cyc;
                break;
            end
        end
        check_eq(p == 0 ? "core_gnt_seen" : "dbg_gnt_seen", 64'(n >= 0), 64'(1));
        @(posedge clk);
        #1;
        if (p == 0) core_req_i = 1'b0;
        else        dbg_req_i  = 1'b0;
    endtask

    task automatic issue(input int p, input logic wr, input logic [18:0] addr,
                         input logic [1:0] be, input logic [18:0] wdata, output int n);
        set_req(p, wr, addr, be, wdata);
        wait_gnt(p, n);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, 64'({core_gnt_o, dbg_gnt_o, core_rvalid_o, dbg_rvalid_o,
                                      mem_req_o, mem_wr_o, mem_byte_en_o, busy_o}), 64'(0));
        check_eq({tag, "_rdata"}, 64'({core_rdata_o, dbg_rdata_o}), 64'(0));
        check_eq({tag, "_mem"}, 64'({mem_addr_o, mem_wr_data_o}), 64'(0));
    endtask

    task automatic sweep_run(input int which);
        int g;
        g = 0;
        if (which == 0) s1_req = 1'b1;
        else            s7_req = 1'b1;
        for (int k = 0; k < 200 && g < 5; k++) begin
            @(negedge clk);
            if ((which == 0) ? s1_gnt : s7_gnt) g++;
        end
        @(posedge clk);
        #1;
        if (which == 0) s1_req = 1'b0;
        else            s7_req = 1'b0;
    endtask

    // ---------------- sweep stimulus ----------------
    logic sweep_done = 1'b0;
    initial begin
        s1_req = 1'b0;
        s7_req = 1'b0;
        sweep_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 sweep_rst_n = 1'b1;
        fork
            sweep_run(0);
            sweep_run(1);
        join
        repeat (15) @(posedge clk);
        sweep_done = 1'b1;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, g, rv_seen;
        logic [18:0] d0, d1;
        for (int i = 0; i < 2; i++) begin
            out_gnt_cyc[i] = 0; out_wr[i] = 1'b0; last_rv_cyc[i] = 0; rv_count[i] = 0;
        end
        reset_n = 1'b0;
        core_req_i = 1'b0; core_wr_i = 1'b0; core_addr_i = '0; core_byte_en_i = '0; core_wr_data_i = '0;
        dbg_req_i  = 1'b0; dbg_wr_i  = 1'b0; dbg_addr_i  = '0; dbg_byte_en_i  = '0; dbg_wr_data_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Core write: grant N, strobe N+1, rvalid N+2, debug port silent.
        issue(0, 1'b1, 19'h00010, WORD, 19'h4ABCD, n);
        @(negedge clk);
        check_eq("write_busy", 64'(busy_o), 64'(1));
        check_eq("write_dbg_quiet", 64'({dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o}), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check_eq("write_rv_cycle", 64'(last_rv_cyc[0] - n), 64'(2));

        // Debug read of 0x00020 returning 0x12345 at N+5.
        issue(1, 1'b0, 19'h00020, WORD, 19'd0, n);
        repeat (7) @(posedge clk);
        #1;
        check_eq("dbg_read_rv_cycle", 64'(last_rv_cyc[1] - n), 64'(5));
        check_eq("dbg_read_count", 64'(rv_count[1]), 64'(1));

        // Both ports request continuously: CORE, DBG, CORE, DBG.
        gnt_log_q.delete();
        d0 = 19'($urandom_range(0, 19'h7FFFF));
        d1 = 19'($urandom_range(0, 19'h7FFFF));
        fork
            begin
                int a;
                issue(0, 1'b1, 19'h00030, HALF_WORD, d0, a);
                issue(0, 1'b0, 19'h00031, BYTE, 19'd0, a);
            end
            begin
                int b;
                issue(1, 1'b0, 19'h00042, WORD, 19'd0, b);
                issue(1, 1'b1, 19'h00043, BYTE, d1, b);
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check_eq("tie_gnt_count", 64'(gnt_log_q.size()), 64'(4));
        if (gnt_log_q.size() == 4) begin
            check_eq("tie_order", 64'({gnt_log_q[0], gnt_log_q[1], gnt_log_q[2], gnt_log_q[3]}), 64'(4'b0101));
        end

        // Debug request raised while a core read waits: granted the cycle after RESP.
        issue(0, 1'b0, 19'h00050, WORD, 19'd0, n);
        @(posedge clk);
        #1;
        set_req(1, 1'b1, 19'h00051, BYTE, 19'($urandom_range(0, 19'h7FFFF)));
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check_eq("busy_no_gnt", 64'(dbg_gnt_o), 64'(0));
        end
        wait_gnt(1, g);
        check_eq("busy_gnt_cycle", 64'(g - n), 64'(6));
        repeat (5) @(posedge clk);
        #1;

        // Reset during WAIT: outputs clear at once, no completion afterwards.
        issue(0, 1'b0, 19'h00060, WORD, 19'd0, n);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("abort_in_wait", 64'(busy_o), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        core_exp_q.delete();
        mem_exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (core_rvalid_o || dbg_rvalid_o) rv_seen++;
        end
        check_eq("no_rvalid_after_reset", 64'(rv_seen), 64'(0));
        @(posedge clk);
        #1;
        gnt_log_q.delete();
        fork
            begin
                int a;
                issue(0, 1'b1, 19'h00070, WORD, 19'h00A5A, a);
            end
            begin
                int b;
                issue(1, 1'b1, 19'h00071, WORD, 19'h05A5A, b);
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check_eq("post_reset_gnt_count", 64'(gnt_log_q.size()), 64'(2));
        if (gnt_log_q.size() >= 1)
            check_eq("post_reset_tie_core", 64'(gnt_log_q[0]), 64'(0));

        // Latency sweep results.
        for (int k = 0; k < 300 && !sweep_done; k++) @(posedge clk);
        check_eq("sweep_done", 64'(sweep_done), 64'(1));
        check_eq("lat1_rv_count", 64'(s1_n), 64'(5));
        check_eq("lat7_rv_count", 64'(s7_n), 64'(5));

        // Drain.
        repeat (10) @(posedge clk);
        #1;
        check_eq("core_exp_q_empty", 64'(core_exp_q.size()), 64'(0));
        check_eq("dbg_exp_q_empty", 64'(dbg_exp_q.size()), 64'(0));
        check_eq("mem_exp_q_empty", 64'(mem_exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory. It sits between the memory and two requesters: the core data port (`data_mem` outputs) and the debug/DMA port. It grants the memory round-robin, issues one registered transaction at a time, and times read returns with a fixed-latency counter. It returns raw memory data; sign/zero extension stays in the core data path.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles from `mem_req_o` to valid `mem_rd_data_i`. Legal range is 1..7.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `core_req_i` / `dbg_req_i`, in, 1 each: request. Held high, with stable payload, until the matching grant.
- `core_addr_i` / `dbg_addr_i`, in, 19 each: word address.
- `core_byte_en_i` / `dbg_byte_en_i`, in, 2 each: access size. Encoding is BYTE / HALF_WORD / WORD from `pkgs`.
- `core_wr_i` / `dbg_wr_i`, in, 1 each: 1 = write, 0 = read.
- `core_wr_data_i` / `dbg_wr_data_i`, in, 19 each: write data.
- `core_gnt_o` / `dbg_gnt_o`, out, 1 each: one-cycle pulse. The request is accepted in that cycle.
- `core_rvalid_o` / `dbg_rvalid_o`, out, 1 each: one-cycle completion pulse. Reads return data with it; writes are acknowledged with it.
- `core_rdata_o` / `dbg_rdata_o`, out, 19 each: read data. Valid only with rvalid; otherwise 0.
- `mem_req_o`, out, 1: memory strobe, one cycle per transaction.
- `mem_addr_o`, out, 19: memory address.
- `mem_byte_en_o`, out, 2: memory access size.
- `mem_wr_o`, out, 1: memory write enable.
- `mem_wr_data_o`, out, 19: memory write data.
- `mem_rd_data_i`, in, 19: memory read data, valid exactly `RD_LAT` cycles after `mem_req_o`.
- `busy_o`, out, 1: high in every state except IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - With any request present, assert the selected grant combinationally, latch the payload and the owner, and go to ISSUE.
  - Grants are only ever given in IDLE.
- **Arbitration:**
  - A single requester wins outright.
  - If both request, the port that is not `last_owner` wins.
  - `last_owner` updates on every grant and resets to DBG, so the core wins the first tie.
- **ISSUE:**
  - Drive `mem_*` from the latched payload with `mem_req_o`=1 for exactly one cycle.
  - Write: go to RESP. Read: load the counter with `RD_LAT`-1 and go to WAIT.
- **WAIT:**
  - Decrement the counter.
  - When the counter is 0, capture `mem_rd_data_i` into the response register and go to RESP.
- **RESP:**
  - Pulse the owner's rvalid. Reads drive the captured data; writes drive 0.
  - Go to IDLE.
- **Memory outputs:** all `mem_*` outputs are 0 outside ISSUE.
- **Non-owner outputs:** rvalid/rdata of the non-owner port stay 0 throughout.
- **Requests during a transaction:**
  - A request arriving in ISSUE/WAIT/RESP waits.
  - It is arbitrated on the next IDLE cycle against whatever is pending then.
- **Protocol rule (bench assertion):** dropping a request or changing its payload before the grant is illegal.
- **Reset mid-transaction:**
  - Immediately return to IDLE, with every output 0 and `last_owner`=DBG.
  - No rvalid for the aborted access.
  - The requester re-issues.

## Timing
- **Reset values:** every output 0; state IDLE; counter 0; `last_owner`=DBG.
- **Grant:** grant in cycle N means `mem_req_o` in cycle N+1.
- **Write latency:** rvalid in N+2.
- **Read latency:** capture in N+1+`RD_LAT`, rvalid in N+2+`RD_LAT`.
- **Throughput:** next grant no earlier than the IDLE cycle after RESP.
  - Writes: 3 cycles per transaction.
  - Reads: 3+`RD_LAT` cycles per transaction.
- **Grant width:** grant is never asserted to both ports, nor for more than one cycle per transaction.

## Structure
- **Package `pkgs`:**
  - `arb_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `port_t` with CORE=0, DBG=1.
  - Reuse the existing BYTE/HALF_WORD/WORD constants.
- **Sub-module `rr_arb2`:** combinational two-way round-robin pick (`req[1:0]`, `last_owner` → `gnt[1:0]`). Counter, FSM and payload registers stay in `dmem_arbiter`.

## Test plan
- **Core write:** core writes addr 0x00010, data 0x4ABCD, WORD, in cycle N → `core_gnt_o` at N; `mem_req_o`/`mem_wr_o`=1 with matching addr/data at N+1; `core_rvalid_o` at N+2; dbg outputs stay 0.
- **Debug read, `RD_LAT`=3:** dbg reads 0x00020 and memory returns 0x12345 → `dbg_rvalid_o` at N+5 with `dbg_rdata_o`=0x12345; 0 in all other cycles.
- **Simultaneous requests after reset:** both request continuously for 4 transactions → grants go CORE, DBG, CORE, DBG; never two grants in one cycle.
- **Request during busy:** dbg raises a request while a core read is in WAIT → no grant until IDLE; dbg is granted in the cycle after core RESP.
- **Reset mid-read:** `reset_n` goes low during WAIT → all outputs 0 asynchronously; no rvalid after release; the next tie goes to the core.
- **Sweep:** `RD_LAT`=1 and 7 with back-to-back reads → rvalid spacing 4 and 10 cycles respectively.
